// File: rtl/sr_cmd_pkg.sv
// Shared constants, types and helpers for the SR command front-end.
// Conflict policy codes and debounce counter sizing.
package sr_cmd_pkg;

  localparam int PRIO_DROP = 0;
  localparam int PRIO_SET  = 1;
  localparam int PRIO_CLR  = 2;

  typedef struct packed {
    logic s;
    logic r;
    logic conflict;
  } cmd_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer producing a stable level.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl
);

  localparam int            CW   = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], din};
      if (r_sync[1] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // Nth consecutive disagreeing sample: accept the new level.
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign lvl = r_lvl;

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced push-button front-end producing single-cycle, arbitrated s/r pulses
// for an SR flip-flop; all outputs are registered.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRIORITY        = PRIO_DROP
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
  output logic s,
  output logic r,
  output logic set_lvl,
  output logic clr_lvl,
  output logic conflict
);

  logic [1:0] w_btn;
  logic [1:0] w_lvl;
  logic [1:0] w_rise;
  logic [1:0] r_lvl_d;
  cmd_t       w_cmd;
  cmd_t       r_cmd;

  // Channel 0 is set, channel 1 is clear.
  assign w_btn = {clr_btn, set_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    sr_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk (clk),
      .rst (rst),
      .din (w_btn[gi]),
      .lvl (w_lvl[gi])
    );
  end

  assign w_rise = w_lvl & ~r_lvl_d;

  always_comb begin
    w_cmd = '0;
    case (w_rise)
      2'b01: w_cmd.s = 1'b1;
      2'b10: w_cmd.r = 1'b1;
      2'b11: begin
        w_cmd.conflict = 1'b1;
        w_cmd.s        = (PRIORITY == PRIO_SET);
        w_cmd.r        = (PRIORITY == PRIO_CLR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl_d <= '0;
      r_cmd   <= '0;
    end else begin
      r_lvl_d <= w_lvl;
      r_cmd   <= w_cmd;
    end
  end

  assign s        = r_cmd.s;
  assign r        = r_cmd.r;
  assign conflict = r_cmd.conflict;
  assign set_lvl  = w_lvl[0];
  assign clr_lvl  = w_lvl[1];

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: three instances (one per conflict policy) share the inputs
// and are compared each cycle against a sample-window reference model.
module tb_sr_cmd_gen;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_btn;
  logic       clr_btn;
  logic [2:0] s_o, r_o, c_o, sl_o, cl_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sr_cmd_gen #(
      .DEBOUNCE_CYCLES(N),
      .PRIORITY       (gi)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .set_btn  (set_btn),
      .clr_btn  (clr_btn),
      .s        (s_o[gi]),
      .r        (r_o[gi]),
      .set_lvl  (sl_o[gi]),
      .clr_lvl  (cl_o[gi]),
      .conflict (c_o[gi])
    );
  end

  // Reference: raw sample history per button; the level flips once the last N
  // synchronised samples (two edges old) all disagree with it.
  logic [N:0] mh_set, mh_clr;
  logic       m_set_lvl, m_clr_lvl, m_set_lvl_d, m_clr_lvl_d;
  logic [2:0] m_s, m_r, m_c;
  logic       m_rise_s, m_rise_c;

  function automatic logic settle(input logic lvl, input logic [N:0] h);
    return (h[N:1] == {N{~lvl}}) ? ~lvl : lvl;
  endfunction

  assign m_rise_s = m_set_lvl & ~m_set_lvl_d;
  assign m_rise_c = m_clr_lvl & ~m_clr_lvl_d;

  always @(posedge clk) begin
    if (rst) begin
      mh_set <= '0; mh_clr <= '0;
      m_set_lvl <= 1'b0; m_clr_lvl <= 1'b0;
      m_set_lvl_d <= 1'b0; m_clr_lvl_d <= 1'b0;
      m_s <= '0; m_r <= '0; m_c <= '0;
    end else begin
      mh_set      <= {mh_set[N-1:0], set_btn};
      mh_clr      <= {mh_clr[N-1:0], clr_btn};
      m_set_lvl   <= settle(m_set_lvl, mh_set);
      m_clr_lvl   <= settle(m_clr_lvl, mh_clr);
      m_set_lvl_d <= m_set_lvl;
      m_clr_lvl_d <= m_clr_lvl;
      m_c         <= {3{m_rise_s & m_rise_c}};
      if (m_rise_s & m_rise_c) begin
        m_s <= 3'b010;  // instance 1: set wins
        m_r <= 3'b100;  // instance 2: clear wins
      end else begin
        m_s <= {3{m_rise_s}};
        m_r <= {3{m_rise_c}};
      end
    end
  end

  logic [14:0] obs, exp_v;
  assign obs   = {s_o, r_o, c_o, sl_o, cl_o};
  assign exp_v = {m_s, m_r, m_c, {3{m_set_lvl}}, {3{m_clr_lvl}}};

  always @(negedge clk) begin
    if (|(s_o & r_o) === 1'b1) begin
      fails++;
      $display("FAIL s_and_r t=%0t s=%b r=%b required s&r=000", $time, s_o, r_o);
    end
  end

  task automatic settle_idle();
    set_btn = 1'b0; clr_btn = 1'b0;
    repeat (2 * N + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] want;
    rst = 1'b1; set_btn = 1'b1; clr_btn = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      tests++;
      if (obs !== 15'b0) begin
        fails++;
        $display("FAIL reset_state j=%0d got=%b required=%b", j, obs, 15'b0);
      end
    end
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      want = (j == 7) ? {3'b010, 3'b100, 3'b111} : 9'b0;
      tests++;
      if ({s_o, r_o, c_o} !== want) begin
        fails++;
        $display("FAIL reset_release j=%0d got s/r/c=%b required=%b", j, {s_o, r_o, c_o}, want);
      end
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL reset_model j=%0d got=%b required=%b", j, obs, exp_v);
      end
    end
    settle_idle();
  endtask

  task automatic test_clean_press();
    set_btn = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      tests++;
      if (s_o !== ((j == 7) ? 3'b111 : 3'b000) || r_o !== 3'b000 ||
          sl_o !== ((j >= 6) ? 3'b111 : 3'b000)) begin
        fails++;
        $display("FAIL clean_press j=%0d got s=%b r=%b lvl=%b required s=%b r=000 lvl=%b",
                 j, s_o, r_o, sl_o, (j == 7) ? 3'b111 : 3'b000, (j >= 6) ? 3'b111 : 3'b000);
      end
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL clean_model j=%0d got=%b required=%b", j, obs, exp_v);
      end
    end
    settle_idle();
  endtask

  task automatic test_glitch();
    int pulses, lvl_seen, want;
    for (int len = N - 1; len <= N; len++) begin
      pulses = 0; lvl_seen = 0;
      clr_btn = 1'b1;
      for (int j = 1; j <= 20; j++) begin
        @(negedge clk);
        if (r_o[0] === 1'b1) pulses++;
        if (cl_o[0] === 1'b1) lvl_seen = 1;
        tests++;
        if (obs !== exp_v) begin
          fails++;
          $display("FAIL glitch_model len=%0d j=%0d got=%b required=%b", len, j, obs, exp_v);
        end
        if (j == len) clr_btn = 1'b0;
      end
      want = (len >= N) ? 1 : 0;
      tests++;
      if (pulses != want || lvl_seen != want) begin
        fails++;
        $display("FAIL glitch len=%0d got pulses=%0d lvl_seen=%0d required %0d/%0d",
                 len, pulses, lvl_seen, want, want);
      end
      settle_idle();
    end
  endtask

  task automatic test_coincident();
    logic [8:0] want;
    set_btn = 1'b1; clr_btn = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      want = (j == 7) ? {3'b010, 3'b100, 3'b111} : 9'b0;
      tests++;
      if ({s_o, r_o, c_o} !== want) begin
        fails++;
        $display("FAIL coincident j=%0d got s/r/c=%b required=%b", j, {s_o, r_o, c_o}, want);
      end
    end
    settle_idle();
  endtask

  task automatic test_staggered();
    set_btn = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      tests++;
      if (s_o !== ((j == 7) ? 3'b111 : 3'b000) || r_o !== ((j == 17) ? 3'b111 : 3'b000) ||
          c_o !== 3'b000) begin
        fails++;
        $display("FAIL staggered j=%0d got s=%b r=%b c=%b", j, s_o, r_o, c_o);
      end
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL staggered_model j=%0d got=%b required=%b", j, obs, exp_v);
      end
      if (j == 10) clr_btn = 1'b1;
    end
    settle_idle();
  endtask

  task automatic test_reset_mid();
    set_btn = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      tests++;
      if (s_o !== 3'b000 || sl_o !== 3'b000) begin
        fails++;
        $display("FAIL reset_mid j=%0d got s=%b lvl=%b required s=000 lvl=000", j, s_o, sl_o);
      end
      if (j == 3) rst = 1'b1;
      if (j == 4) begin rst = 1'b0; set_btn = 1'b0; end
    end
    settle_idle();
  endtask

  task automatic test_random();
    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL random_model j=%0d got=%b required=%b", j, obs, exp_v);
      end
      if ($urandom_range(0, 5) == 0) set_btn = ~set_btn;
      if ($urandom_range(0, 5) == 0) clr_btn = ~clr_btn;
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    settle_idle();
  endtask

  initial begin
    rst = 1'b1; set_btn = 1'b0; clr_btn = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_coincident();
    test_staggered();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
